// File: rtl/s_seq_div4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | s_seq_div4 : sequential 8/4 signed restoring divider (IDLE/CALC/SIGN/DONE) |
// | Optional: S_SEQ_DIV4_ABORT_EN adds an abort input.  Rev 1.0           |
// +----------------------------------------------------------------------+
module s_seq_div4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [3:0] b,
`ifdef S_SEQ_DIV4_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] quo,
  output logic [3:0] rem,
  output logic       dbz,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_LAST_STEP = 8'd7;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_qmag;
  logic [3:0] r_part;
  logic [3:0] r_bmag;
  logic [7:0] r_cnt;
  logic       r_neg_q;
  logic       r_neg_r;
  logic       r_zero;
  logic       r_ovf_case;
  logic       w_abort;
  logic [4:0] w_shift;
  logic       w_ge;

`ifdef S_SEQ_DIV4_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_shift = {r_part, r_qmag[7]};
  assign w_ge    = (w_shift >= {1'b0, r_bmag});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      // A zero divisor still passes through SIGN so its result lands one edge later.
      IDLE: if (start) w_next = (b == 4'd0) ? SIGN : CALC;
      CALC: begin
        busy = 1'b1;
        if (w_abort)                 w_next = IDLE;
        else if (r_cnt == c_LAST_STEP) w_next = SIGN;
      end
      SIGN: begin
        busy   = 1'b1;
        w_next = w_abort ? IDLE : DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qmag     <= 8'd0;
      r_part     <= 4'd0;
      r_bmag     <= 4'd0;
      r_cnt      <= 8'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf_case <= 1'b0;
      quo        <= 8'd0;
      rem        <= 4'd0;
      dbz        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_qmag     <= a[7] ? (~a + 8'd1) : a;
          r_bmag     <= b[3] ? (~b + 4'd1) : b;
          r_part     <= 4'd0;
          r_cnt      <= 8'd0;
          r_neg_q    <= a[7] ^ b[3];
          r_neg_r    <= a[7];
          r_zero     <= (b == 4'd0);
          r_ovf_case <= (a == 8'h80) && (b == 4'hF);
        end
        CALC: if (!w_abort) begin
          // Partial remainder stays below |b| <= 8, so 4 bits hold it.
          r_part <= 4'(w_ge ? (w_shift - {1'b0, r_bmag}) : w_shift);
          r_qmag <= {r_qmag[6:0], w_ge};
          r_cnt  <= r_cnt + 8'd1;
        end
        SIGN: if (!w_abort) begin
          if (r_zero) begin
            quo <= 8'h00;
            rem <= 4'h0;
          end else begin
            quo <= r_neg_q ? (~r_qmag + 8'd1) : r_qmag;
            rem <= r_neg_r ? (~r_part + 4'd1) : r_part;
          end
          dbz <= r_zero;
          ovf <= r_ovf_case;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
